// File: rtl/rf2p_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rf2p_arbiter_pkg
// Shared configuration for the two-port register-file arbiter slice:
//   RD_LAT     - cycles from read grant to returned read data
//   RFPort     - read/write port naming, used when labelling debug views
//   onehot2idx - converts a one-hot grant vector (up to 8 requesters) to
//                the binary index of the set bit
// -----------------------------------------------------------------------------
package rf2p_arbiter_pkg;

    localparam int RD_LAT = 1;

    typedef enum logic {
        PORT_RD = 1'b0,
        PORT_WR = 1'b1
    } RFPort;

    // One-hot to binary; a zero vector maps to index 0.
    function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rf2p_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with its own rotating priority pointer. The grant is
// combinational: the first asserted request at or after the pointer wins.
// When i_adv is high and a grant is present, the pointer moves to the slot
// after the winner, so the winner gets lowest priority next time.
// Ports:
//   i_clk, i_rst_n - clock, asynchronous active-low reset (pointer -> 0)
//   i_req          - request vector
//   i_adv          - allow the pointer to advance on a grant
//   o_gnt          - one-hot grant (all zero when nothing requests)
//   o_idx          - binary index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter
    import rf2p_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_adv,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDXW-1:0] o_idx
);

    localparam logic [IDXW:0] NREQ_W = (IDXW+1)'(NREQ);

    logic [IDXW-1:0] ptr_q;
    logic [IDXW-1:0] ptr_d;
    logic [NREQ-1:0] gnt_s;
    logic [IDXW-1:0] idx_s;
    logic [IDXW-1:0] cand_s;
    logic            found_s;
    logic [7:0]      gnt_ext_s;

    // (base + off) modulo NREQ without a divider; base < NREQ and off <= NREQ.
    function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base,
                                                 input logic [IDXW:0]   off);
        logic [IDXW:0] sum;
        sum = {1'b0, base} + off;
        if (sum >= NREQ_W) begin
            sum = sum - NREQ_W;
        end else begin
            sum = sum;
        end
        return sum[IDXW-1:0];
    endfunction

    // Scan requesters starting at the pointer; the first hit takes the grant.
    always_comb begin
        gnt_s   = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s = wrap_add(ptr_q, (IDXW+1)'(i));
            if (!found_s && i_req[cand_s]) begin
                gnt_s[cand_s] = 1'b1;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Binary index of the winner, used for the pointer update and muxing.
    always_comb begin
        gnt_ext_s            = 8'd0;
        gnt_ext_s[NREQ-1:0]  = gnt_s;
        idx_s                = IDXW'(onehot2idx(gnt_ext_s));
    end

    // Next pointer: slot after the winner on an accepted grant, else hold.
    always_comb begin
        if (i_adv && found_s) begin
            ptr_d = wrap_add(idx_s, (IDXW+1)'(1));
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Priority pointer register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign o_gnt = gnt_s;
    assign o_idx = idx_s;

endmodule

// File: rtl/rf2p_arbiter.sv
// -----------------------------------------------------------------------------
// rf2p_arbiter
// Shares one RF2P macro (one read port, one write port) among NREQ requesters.
// Read and write ports are arbitrated independently, each round-robin. A read
// whose address matches the write granted in the same cycle is withheld for
// that cycle, so it is granted later and sees the freshly written data.
// Read data comes back one cycle after the grant, tagged by a one-hot valid.
// Ports:
//   i_clk, i_rst_n           - clock, asynchronous active-low reset
//   i_rreq/i_raddr           - per-requester read request and address slice
//   o_rgnt                   - one-hot read grant (same cycle)
//   o_rvalid/o_rdata         - one-hot read-return valid and broadcast data
//   i_wreq/i_waddr/i_wdata   - per-requester write request, address, data
//   o_wgnt                   - one-hot write grant (same cycle)
//   o_rf_read/o_rf_raddr     - macro read enable and address
//   i_rf_rdata               - macro read data, one cycle after o_rf_read
//   o_rf_write/o_rf_waddr/o_rf_wdata - macro write enable, address, data
//   o_conflict               - a read was withheld this cycle by a collision
// -----------------------------------------------------------------------------
module rf2p_arbiter
    import rf2p_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DWD  = 16,
    parameter int AWD  = 6
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NREQ-1:0]     i_rreq,
    input  logic [NREQ*AWD-1:0] i_raddr,
    output logic [NREQ-1:0]     o_rgnt,
    output logic [NREQ-1:0]     o_rvalid,
    output logic [DWD-1:0]      o_rdata,
    input  logic [NREQ-1:0]     i_wreq,
    input  logic [NREQ*AWD-1:0] i_waddr,
    input  logic [NREQ*DWD-1:0] i_wdata,
    output logic [NREQ-1:0]     o_wgnt,
    output logic                o_rf_read,
    output logic [AWD-1:0]      o_rf_raddr,
    input  logic [DWD-1:0]      i_rf_rdata,
    output logic                o_rf_write,
    output logic [AWD-1:0]      o_rf_waddr,
    output logic [DWD-1:0]      o_rf_wdata,
    output logic                o_conflict
);

    localparam int IDXW = $clog2(NREQ);

    logic [NREQ-1:0] wgnt_s;
    logic [IDXW-1:0] widx_s;
    logic            rf_write_s;
    logic [AWD-1:0]  rf_waddr_s;
    logic [DWD-1:0]  rf_wdata_s;

    logic [NREQ-1:0] rcand_s;
    logic [NREQ-1:0] rblock_s;
    logic [NREQ-1:0] rgnt_s;
    logic [IDXW-1:0] ridx_s;
    logic            rf_read_s;
    logic [AWD-1:0]  rf_raddr_s;

    logic [NREQ-1:0] rvalid_q;
    logic [NREQ-1:0] rvalid_d;
    logic [DWD-1:0]  rdata_s;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_wr_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (i_wreq),
        .i_adv   (1'b1),
        .o_gnt   (wgnt_s),
        .o_idx   (widx_s)
    );

    // Route the winning writer's address and data to the macro write port.
    always_comb begin
        rf_write_s = |wgnt_s;
        if (rf_write_s) begin
            rf_waddr_s = i_waddr[int'(widx_s)*AWD +: AWD];
            rf_wdata_s = i_wdata[int'(widx_s)*DWD +: DWD];
        end else begin
            rf_waddr_s = '0;
            rf_wdata_s = '0;
        end
    end

    // Drop readers that target the address being written this cycle; they
    // retry next cycle and so observe the new data instead of stale contents.
    always_comb begin
        rcand_s  = '0;
        rblock_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (rf_write_s && (i_raddr[k*AWD +: AWD] == rf_waddr_s)) begin
                rblock_s[k] = i_rreq[k];
                rcand_s[k]  = 1'b0;
            end else begin
                rblock_s[k] = 1'b0;
                rcand_s[k]  = i_rreq[k];
            end
        end
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rd_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (rcand_s),
        .i_adv   (1'b1),
        .o_gnt   (rgnt_s),
        .o_idx   (ridx_s)
    );

    // Route the winning reader's address to the macro read port.
    always_comb begin
        rf_read_s = |rgnt_s;
        if (rf_read_s) begin
            rf_raddr_s = i_raddr[int'(ridx_s)*AWD +: AWD];
        end else begin
            rf_raddr_s = '0;
        end
    end

    // The macro answers one cycle after the read, so the valid tag is the
    // grant delayed by one cycle.
    always_comb begin
        rvalid_d = rgnt_s;
    end

    // Read-return tag register; reset discards any read still in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rvalid_q <= '0;
        end else begin
            rvalid_q <= rvalid_d;
        end
    end

    // Only pass macro data through while a return is actually valid.
    always_comb begin
        if (|rvalid_q) begin
            rdata_s = i_rf_rdata;
        end else begin
            rdata_s = '0;
        end
    end

    assign o_wgnt     = wgnt_s;
    assign o_rf_write = rf_write_s;
    assign o_rf_waddr = rf_waddr_s;
    assign o_rf_wdata = rf_wdata_s;
    assign o_rgnt     = rgnt_s;
    assign o_rf_read  = rf_read_s;
    assign o_rf_raddr = rf_raddr_s;
    assign o_conflict = |rblock_s;
    assign o_rvalid   = rvalid_q;
    assign o_rdata    = rdata_s;

endmodule

// File: tb/tb_rf2p_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf2p_arbiter
// Self-checking bench for rf2p_arbiter. The bench plays the requesters and the
// RF2P macro; a reference model (pointer integers plus a shadow memory array)
// predicts grants, macro controls, conflict and the returned data.
// -----------------------------------------------------------------------------
module tb_rf2p_arbiter;
    import rf2p_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int DWD  = 16;
    localparam int AWD  = 6;
    localparam int DEPTH = 64;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     i_rreq = '0;
    logic [NREQ*AWD-1:0] i_raddr = '0;
    logic [NREQ-1:0]     o_rgnt;
    logic [NREQ-1:0]     o_rvalid;
    logic [DWD-1:0]      o_rdata;
    logic [NREQ-1:0]     i_wreq = '0;
    logic [NREQ*AWD-1:0] i_waddr = '0;
    logic [NREQ*DWD-1:0] i_wdata = '0;
    logic [NREQ-1:0]     o_wgnt;
    logic                o_rf_read;
    logic [AWD-1:0]      o_rf_raddr;
    logic [DWD-1:0]      rf_rdata;
    logic                o_rf_write;
    logic [AWD-1:0]      o_rf_waddr;
    logic [DWD-1:0]      o_rf_wdata;
    logic                o_conflict;

    always #5 clk = ~clk;

    rf2p_arbiter #(.NREQ(NREQ), .DWD(DWD), .AWD(AWD)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rreq     (i_rreq),
        .i_raddr    (i_raddr),
        .o_rgnt     (o_rgnt),
        .o_rvalid   (o_rvalid),
        .o_rdata    (o_rdata),
        .i_wreq     (i_wreq),
        .i_waddr    (i_waddr),
        .i_wdata    (i_wdata),
        .o_wgnt     (o_wgnt),
        .o_rf_read  (o_rf_read),
        .o_rf_raddr (o_rf_raddr),
        .i_rf_rdata (rf_rdata),
        .o_rf_write (o_rf_write),
        .o_rf_waddr (o_rf_waddr),
        .o_rf_wdata (o_rf_wdata),
        .o_conflict (o_conflict)
    );

    // Requester-side state
    bit             rq_r [NREQ];
    logic [AWD-1:0] ra   [NREQ];
    bit             rq_w [NREQ];
    logic [AWD-1:0] wa   [NREQ];
    logic [DWD-1:0] wd   [NREQ];

    // Reference model
    int             m_ptr_r;
    int             m_ptr_w;
    logic [DWD-1:0] ref_mem [DEPTH];

    // Last sampled DUT outputs for directed checks
    logic [NREQ-1:0] s_wgnt, s_rgnt, s_rvalid;
    logic            s_conf;
    logic [DWD-1:0]  s_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    // RF2P macro behavioural model: synchronous read, synchronous write.
    logic [DWD-1:0] rf_mem [DEPTH];
    initial begin
        rf_rdata = '0;
        for (int a = 0; a < DEPTH; a++) rf_mem[a] = 16'hA000 + 16'(a);
        forever begin
            @(posedge clk);
            if (o_rf_read)  rf_rdata <= rf_mem[o_rf_raddr];
            if (o_rf_write) rf_mem[o_rf_waddr] <= o_rf_wdata;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    endtask

    task automatic drive();
        for (int k = 0; k < NREQ; k++) begin
            i_rreq[k] = rq_r[k];
            i_raddr[k*AWD +: AWD] = ra[k];
            i_wreq[k] = rq_w[k];
            i_waddr[k*AWD +: AWD] = wa[k];
            i_wdata[k*DWD +: DWD] = wd[k];
        end
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < NREQ; k++) begin
            rq_r[k] = 1'b0; rq_w[k] = 1'b0;
        end
    endtask

    // One bus cycle: entered just after a rising edge. Applies the current
    // requests, checks the combinational side against the model, then checks
    // the read return after the edge and retires granted requests.
    task automatic step();
        int w, r, k;
        logic [NREQ-1:0] blocked;
        logic [NREQ-1:0] exp_rv;
        logic [DWD-1:0]  exp_rd;
        drive();
        #2;
        w = -1;
        for (int off = 0; off < NREQ; off++) begin
            k = (m_ptr_w + off) % NREQ;
            if (w < 0 && rq_w[k]) w = k;
        end
        blocked = '0;
        for (int j = 0; j < NREQ; j++)
            if (rq_r[j] && w >= 0 && ra[j] == wa[w]) blocked[j] = 1'b1;
        r = -1;
        for (int off = 0; off < NREQ; off++) begin
            k = (m_ptr_r + off) % NREQ;
            if (r < 0 && rq_r[k] && !blocked[k]) r = k;
        end
        s_wgnt = o_wgnt; s_rgnt = o_rgnt; s_conf = o_conflict;
        check_val("wgnt",     32'(o_wgnt), (w >= 0) ? (32'd1 << w) : 32'd0);
        check_val("rf_write", 32'(o_rf_write), (w >= 0) ? 32'd1 : 32'd0);
        if (w >= 0) begin
            check_val("rf_waddr", 32'(o_rf_waddr), 32'(wa[w]));
            check_val("rf_wdata", 32'(o_rf_wdata), 32'(wd[w]));
        end
        check_val("rgnt",     32'(o_rgnt), (r >= 0) ? (32'd1 << r) : 32'd0);
        check_val("rf_read",  32'(o_rf_read), (r >= 0) ? 32'd1 : 32'd0);
        if (r >= 0) check_val("rf_raddr", 32'(o_rf_raddr), 32'(ra[r]));
        check_val("conflict", 32'(o_conflict), (blocked != '0) ? 32'd1 : 32'd0);
        exp_rv = (r >= 0) ? NREQ'(1 << r) : '0;
        exp_rd = (r >= 0) ? ref_mem[ra[r]] : '0;
        if (w >= 0) begin
            ref_mem[wa[w]] = wd[w];
            m_ptr_w = (w + 1) % NREQ;
        end
        if (r >= 0) m_ptr_r = (r + 1) % NREQ;
        repeat (RD_LAT) @(posedge clk);
        #1;
        s_rvalid = o_rvalid; s_rdata = o_rdata;
        check_val("rvalid", 32'(o_rvalid), 32'(exp_rv));
        check_val("rdata",  32'(o_rdata),  32'(exp_rd));
        if (w >= 0) rq_w[w] = 1'b0;
        if (r >= 0) rq_r[r] = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = 16'hA000 + 16'(a);
        for (int k = 0; k < NREQ; k++) begin
            ra[k] = '0; wa[k] = '0; wd[k] = '0;
        end
        clear_reqs();
        m_ptr_r = 0; m_ptr_w = 0;

        // Reset state
        #12;
        check_val("rst_rvalid", 32'(o_rvalid), 32'd0);
        check_val("rst_rdata",  32'(o_rdata),  32'd0);
        check_val("rst_rgnt",   32'(o_rgnt),   32'd0);
        check_val("rst_wgnt",   32'(o_wgnt),   32'd0);
        check_val("rst_rfctl",  32'({o_rf_read, o_rf_write}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All four readers, addresses 0..3: round-robin 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < NREQ; k++) begin
                rq_r[k] = 1'b1; ra[k] = AWD'(k);
            end
            step();
            check_val("t1_rgnt",  32'(s_rgnt),  32'd1 << (i % 4));
            check_val("t1_rdata", 32'(s_rdata), 32'hA000 + 32'(i % 4));
        end
        clear_reqs();

        // Same-address write and read: read withheld, then returns new data
        rq_w[2] = 1'b1; wa[2] = 6'd5; wd[2] = 16'hBEEF;
        rq_r[1] = 1'b1; ra[1] = 6'd5;
        step();
        check_val("t2_wgnt", 32'(s_wgnt), 32'h4);
        check_val("t2_rgnt", 32'(s_rgnt), 32'h0);
        check_val("t2_conf", 32'(s_conf), 32'h1);
        step();
        check_val("t2_rgnt_next", 32'(s_rgnt),   32'h2);
        check_val("t2_rvalid",    32'(s_rvalid), 32'h2);
        check_val("t2_rdata",     32'(s_rdata),  32'hBEEF);

        // Different addresses: both ports granted together
        rq_w[0] = 1'b1; wa[0] = 6'd3; wd[0] = 16'h1234;
        rq_r[3] = 1'b1; ra[3] = 6'd7;
        step();
        check_val("t3_wgnt", 32'(s_wgnt), 32'h1);
        check_val("t3_rgnt", 32'(s_rgnt), 32'h8);
        check_val("t3_conf", 32'(s_conf), 32'h0);

        // Single requester 3, pointer wraps to 0, then 0 beats 3
        for (int i = 0; i < 3; i++) begin
            rq_r[3] = 1'b1; ra[3] = 6'd9;
            step();
            check_val("t4_rgnt", 32'(s_rgnt), 32'h8);
        end
        rq_r[0] = 1'b1; ra[0] = 6'd1;
        rq_r[3] = 1'b1; ra[3] = 6'd9;
        step();
        check_val("t4_rgnt_wrap", 32'(s_rgnt), 32'h1);
        step();
        clear_reqs();

        // Reset while a read return is in flight
        rq_r[1] = 1'b1; ra[1] = 6'd3;
        drive();
        @(posedge clk); #1;
        check_val("t5_rvalid_pre", 32'(o_rvalid), 32'h2);
        clear_reqs(); drive();
        #3;
        rst_n = 1'b0;
        #1;
        check_val("t5_rvalid_rst", 32'(o_rvalid), 32'h0);
        check_val("t5_rdata_rst",  32'(o_rdata),  32'h0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        m_ptr_r = 0; m_ptr_w = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_val("t5_no_spurious", 32'(s_rvalid), 32'h0);
        end

        // All writers: one write per cycle, in order 0..3
        for (int k = 0; k < NREQ; k++) begin
            rq_w[k] = 1'b1; wa[k] = AWD'(10 + k); wd[k] = DWD'(16 + k);
        end
        for (int i = 0; i < NREQ; i++) begin
            step();
            check_val("t6_wgnt", 32'(s_wgnt), 32'd1 << i);
        end
        for (int i = 0; i < NREQ; i++) begin
            rq_r[0] = 1'b1; ra[0] = AWD'(10 + i);
            step();
            check_val("t6_readback", 32'(s_rdata), 32'h10 + 32'(i));
        end

        // Randomized traffic on a small address window to provoke collisions
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!rq_r[k] && $urandom_range(0, 1) == 1) begin
                    rq_r[k] = 1'b1; ra[k] = AWD'($urandom_range(0, 7));
                end
                if (!rq_w[k] && $urandom_range(0, 2) == 0) begin
                    rq_w[k] = 1'b1; wa[k] = AWD'($urandom_range(0, 7));
                    wd[k] = DWD'($urandom);
                end
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
